// File: rtl/key_sched_ctrl_if.sv
// Handshake bundle for the AES-128 key-schedule controller: start/key in,
// shared SubWord unit port pair, and the round-key valid/ready stream.
interface key_sched_ctrl_if;
  logic         start_i;
  logic [127:0] key_i;
  logic [31:0]  sub_word_o;
  logic [31:0]  sub_word_i;
  logic [127:0] rkey_o;
  logic [3:0]   rkey_idx_o;
  logic         rkey_valid_o;
  logic         rkey_ready_i;
  logic         busy_o;
  logic         done_o;

  modport slave (
    input  start_i, key_i, sub_word_i, rkey_ready_i,
    output sub_word_o, rkey_o, rkey_idx_o, rkey_valid_o, busy_o, done_o
  );

  modport master (
    output start_i, key_i, sub_word_i, rkey_ready_i,
    input  sub_word_o, rkey_o, rkey_idx_o, rkey_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/key_sched_ctrl.sv
// AES-128 key expansion sequencer: emits round keys 0..10 over a valid/ready
// stream, borrowing an external SubWord unit with SUB_LAT cycles of latency.
module key_sched_ctrl #(
  parameter int SUB_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  key_sched_ctrl_if.slave ks
);
  typedef enum logic [2:0] {IDLE, EMIT, SUB, MIX, DONE} state_t;

  localparam logic [1:0] CNT_INIT = 2'(SUB_LAT - 1);

  state_t       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [31:0]  temp_q, temp_d;
  logic [3:0]   idx_q, idx_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [1:0]   cnt_q, cnt_d;

  logic [31:0] w0, w1, w2, w3, n0, n1, n2, n3;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return v[7] ? ({v[6:0], 1'b0} ^ 8'h1B) : {v[6:0], 1'b0};
  endfunction

  assign {w0, w1, w2, w3} = key_q;
  assign n0 = w0 ^ temp_q ^ {rcon_q, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    temp_d  = temp_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ks.start_i) begin
        key_d   = ks.key_i;
        idx_d   = '0;
        rcon_d  = 8'h01;
        state_d = EMIT;
      end
      EMIT: if (ks.rkey_ready_i) begin
        if (idx_q == 4'd10) state_d = DONE;
        else begin
          state_d = SUB;
          cnt_d   = CNT_INIT;
        end
      end
      // RotWord is held on sub_word_o for SUB_LAT cycles; the result is
      // taken on the last of them.
      SUB: if (cnt_q == 2'd0) begin
        temp_d  = ks.sub_word_i;
        state_d = MIX;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
      MIX: begin
        key_d   = {n0, n1, n2, n3};
        idx_d   = idx_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        state_d = EMIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      temp_q  <= '0;
      idx_q   <= '0;
      rcon_q  <= 8'h01;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      temp_q  <= temp_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ks.sub_word_o   = (state_q == SUB) ? {w3[23:0], w3[31:24]} : 32'h0;
  assign ks.rkey_o       = key_q;
  assign ks.rkey_idx_o   = idx_q;
  assign ks.rkey_valid_o = (state_q == EMIT);
  assign ks.busy_o       = (state_q != IDLE);
  assign ks.done_o       = (state_q == DONE);
endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl: FIPS-197 and all-zero keys, random
// backpressure, SUB_LAT=3 timing, mid-run reset and ignored starts.
module tb_key_sched_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic start0, start1, ready_v;
  logic [127:0] key_v;
  int checks = 0;
  int failures = 0;
  logic [127:0] exp_rk [0:10];

  always #5 clk = ~clk;

  key_sched_ctrl_if ifc0 ();
  key_sched_ctrl_if ifc1 ();

  key_sched_ctrl #(.SUB_LAT(1)) u0 (.clk_i(clk), .rst_i(rst), .ks(ifc0.slave));
  key_sched_ctrl #(.SUB_LAT(3)) u1 (.clk_i(clk), .rst_i(rst), .ks(ifc1.slave));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h0;
    if (x != 8'h0)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign ifc0.start_i      = start0;
  assign ifc1.start_i      = start1;
  assign ifc0.key_i        = key_v;
  assign ifc1.key_i        = key_v;
  assign ifc0.rkey_ready_i = ready_v;
  assign ifc1.rkey_ready_i = ready_v;
  assign ifc0.sub_word_i   = subw(ifc0.sub_word_o);
  assign ifc1.sub_word_i   = subw(ifc1.sub_word_o);

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [127:0] key);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0] r;
    {w0, w1, w2, w3} = key;
    r = 8'h01;
    exp_rk[0] = key;
    for (int n = 1; n <= 10; n++) begin
      t  = subw({w3[23:0], w3[31:24]}) ^ {r, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      exp_rk[n] = {w0, w1, w2, w3};
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h1B) : {r[6:0], 1'b0};
    end
  endtask

  task automatic run(input bit which, input logic [127:0] key, input bit stall,
                     input bit glitch, input logic [127:0] x1, input logic [127:0] x10,
                     input string nm);
    int lat, hs, dones, last_hs, swrun;
    logic [127:0] cap [0:10];
    logic v, dn, bsy, pv_stall;
    logic [3:0] ix, pix;
    logic [127:0] rk, prk;
    logic [31:0] sw;
    lat = which ? 3 : 1;
    build_exp(key);
    key_v = key; ready_v = 1'b1;
    @(negedge clk);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    hs = 0; dones = 0; last_hs = 0; swrun = 0; pv_stall = 1'b0; prk = '0; pix = '0;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; key_v = key;
      v   = which ? ifc1.rkey_valid_o : ifc0.rkey_valid_o;
      dn  = which ? ifc1.done_o       : ifc0.done_o;
      bsy = which ? ifc1.busy_o       : ifc0.busy_o;
      ix  = which ? ifc1.rkey_idx_o   : ifc0.rkey_idx_o;
      rk  = which ? ifc1.rkey_o       : ifc0.rkey_o;
      sw  = which ? ifc1.sub_word_o   : ifc0.sub_word_o;
      if (dones > 0 && !dn) begin
        chk({nm, "_idle_after_done"}, 128'(bsy), 128'(0));
        break;
      end
      if (pv_stall) begin
        chk({nm, "_stall_rkey"}, rk, prk);
        chk({nm, "_stall_idx"}, 128'(ix), 128'(pix));
        chk({nm, "_stall_valid"}, 128'(v), 128'(1));
      end
      ready_v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (glitch && c == 5) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
        key_v = ~key;
      end
      if (sw != 32'h0) swrun++;
      else if (swrun != 0) begin
        chk({nm, "_sub_len"}, 128'(swrun), 128'(lat));
        swrun = 0;
      end
      if (v && ready_v) begin
        chk({nm, "_idx"}, 128'(ix), 128'(hs));
        if (hs <= 10) begin
          chk({nm, "_rkey"}, rk, exp_rk[hs]);
          cap[hs] = rk;
        end
        if (!stall) chk({nm, "_idx_cycle"}, 128'(c), 128'(1 + hs * (lat + 2)));
        hs++; last_hs = c;
      end
      pv_stall = v && !ready_v; prk = rk; pix = ix;
      if (dn) begin
        dones++;
        chk({nm, "_done_after_hs"}, 128'(c), 128'(last_hs + 1));
        if (!stall) chk({nm, "_done_cycle"}, 128'(c), 128'(2 + 10 * (lat + 2)));
        if (glitch) begin
          if (which) start1 = 1'b1; else start0 = 1'b1;
        end
      end
    end
    chk({nm, "_handshakes"}, 128'(hs), 128'(11));
    chk({nm, "_dones"}, 128'(dones), 128'(1));
    chk({nm, "_key1"}, cap[1], x1);
    chk({nm, "_key10"}, cap[10], x10);
    chk({nm, "_retain"}, which ? ifc1.rkey_o : ifc0.rkey_o, x10);
  endtask

  localparam logic [127:0] FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z1    = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10   = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; key_v = '0; ready_v = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(ifc0.rkey_valid_o), 128'(0));
    chk("rst_busy",  128'(ifc0.busy_o), 128'(0));
    chk("rst_done",  128'(ifc0.done_o), 128'(0));
    chk("rst_sub",   128'(ifc0.sub_word_o), 128'(0));
    chk("rst_rkey",  ifc0.rkey_o, 128'(0));
    chk("rst_idx",   128'(ifc0.rkey_idx_o), 128'(0));
    chk("rst_busy1", 128'(ifc1.busy_o), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_start", 128'(ifc0.busy_o), 128'(0));

    run(1'b0, FIPS, 1'b0, 1'b0, F1, F10, "fips");
    chk("fips_model_anchor", exp_rk[2], 128'hf2c295f27a96b9435935807a7359f67f);
    run(1'b0, 128'h0, 1'b0, 1'b0, Z1, Z10, "zero");
    run(1'b0, FIPS, 1'b1, 1'b0, F1, F10, "stall");
    run(1'b1, FIPS, 1'b0, 1'b0, F1, F10, "lat3");

    // abort during the SUB that follows round key 5
    key_v = FIPS;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (15) @(negedge clk);
    chk("abort_at_idx5_valid", 128'(ifc0.rkey_valid_o), 128'(1));
    chk("abort_at_idx5_idx", 128'(ifc0.rkey_idx_o), 128'(5));
    @(negedge clk);
    chk("abort_in_sub", 128'(ifc0.sub_word_o != 32'h0), 128'(1));
    #1 rst = 1'b1;
    #1;
    chk("abort_sub",   128'(ifc0.sub_word_o), 128'(0));
    chk("abort_rkey",  ifc0.rkey_o, 128'(0));
    chk("abort_idx",   128'(ifc0.rkey_idx_o), 128'(0));
    chk("abort_busy",  128'(ifc0.busy_o), 128'(0));
    chk("abort_valid", 128'(ifc0.rkey_valid_o), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", 128'(ifc0.done_o), 128'(0));
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_needs_start", 128'(ifc0.busy_o), 128'(0));
    end
    run(1'b0, FIPS, 1'b0, 1'b0, F1, F10, "restart");
    run(1'b0, FIPS, 1'b0, 1'b1, F1, F10, "glitch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
